// File: rtl/golden_nonce_arbiter_pkg.sv
// Shared types and helpers for the golden-nonce arbiter.
package golden_nonce_arbiter_pkg;

  localparam int NONCE_W = 32;

  // Widest core index needed for the largest supported core count (16).
  // Narrower configurations zero-extend into this field.
  localparam int CORE_W_MAX = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // One queued report: the nonce and the core that found it.
  typedef struct packed {
    logic [NONCE_W-1:0]    nonce;
    logic [CORE_W_MAX-1:0] core;
  } gn_entry_t;

endpackage

// File: rtl/golden_nonce_arbiter_gn_fifo.sv
// Synchronous show-ahead FIFO: o_rdata always shows the head entry.
// DEPTH must be a power of two so the pointers wrap naturally.
module gn_fifo
  import golden_nonce_arbiter_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents need no reset because o_empty qualifies the head.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/golden_nonce_arbiter.sv
// Golden-nonce arbiter: captures per-core match strobes, serialises them
// round-robin into a show-ahead FIFO and reports them over valid/ready.
// CORE_W must equal clog2(NUM_CORES) (minimum 1); FIFO_DEPTH a power of two.
module golden_nonce_arbiter
  import golden_nonce_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CORE_W     = 2,
  localparam int LVL_W     = clog2(FIFO_DEPTH) + 1
) (
  input  logic                           hash_clk,
  input  logic                           reset_n,
  input  logic [NUM_CORES-1:0]           core_match,
  input  logic [NONCE_W*NUM_CORES-1:0]   core_nonce,
  input  logic [NUM_CORES-1:0]           core_busy,
  output logic                           gn_valid,
  output logic [NONCE_W-1:0]             gn_nonce,
  output logic [CORE_W-1:0]              gn_core,
  input  logic                           gn_ready,
  output logic                           any_busy,
  output logic [7:0]                     drop_cnt,
  output logic [LVL_W-1:0]               fifo_level
);

  localparam int DROP_W = clog2(NUM_CORES + 1);
  localparam int IDX_W  = CORE_W + 1;

  logic [NUM_CORES-1:0] r_pending;
  logic [NONCE_W-1:0]   r_hold [NUM_CORES];
  logic [CORE_W-1:0]    r_rr_ptr;
  logic [7:0]           r_drop_cnt;
  logic                 r_any_busy;

  logic                 w_grant;
  logic [CORE_W-1:0]    w_winner;
  logic [CORE_W-1:0]    w_rr_next;
  logic [NUM_CORES-1:0] w_drop_vec;
  logic [DROP_W-1:0]    w_drop_num;
  logic [8:0]           w_drop_sum;
  logic [7:0]           w_drop_next;
  logic                 w_pop;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [LVL_W-1:0]     w_fifo_count;
  gn_entry_t            w_push_entry;
  gn_entry_t            w_head;

  // Round-robin pick: first pending core at or after rr_ptr, only while the
  // FIFO has room as of the start of the cycle (a same-cycle pop does not count).
  always_comb begin
    logic [IDX_W-1:0] idx;
    w_grant  = 1'b0;
    w_winner = '0;
    idx      = '0;
    if (!w_fifo_full) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        idx = {1'b0, r_rr_ptr} + IDX_W'(k);
        if (idx >= IDX_W'(NUM_CORES)) begin
          idx = idx - IDX_W'(NUM_CORES);
        end
        if (!w_grant && r_pending[idx[CORE_W-1:0]]) begin
          w_grant  = 1'b1;
          w_winner = idx[CORE_W-1:0];
        end
      end
    end
  end

  assign w_rr_next = (w_winner == CORE_W'(NUM_CORES - 1)) ? '0 : w_winner + 1'b1;

  // A new strobe on a core whose previous nonce is still waiting (and not
  // leaving this cycle) overwrites it; count every such loss.
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_drop_vec[i] = core_match[i] && r_pending[i] &&
                      !(w_grant && (w_winner == CORE_W'(i)));
      w_drop_num    = w_drop_num + DROP_W'(w_drop_vec[i]);
    end
    w_drop_sum  = {1'b0, r_drop_cnt} + 9'(w_drop_num);
    w_drop_next = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
  end

  // Capture stage, pending bookkeeping, rr pointer and drop counter.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_match[i]) begin
          r_pending[i] <= 1'b1;
          r_hold[i]    <= core_nonce[i*NONCE_W +: NONCE_W];
        end else if (w_grant && (w_winner == CORE_W'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end
      if (w_grant) begin
        r_rr_ptr <= w_rr_next;
      end
      r_drop_cnt <= w_drop_next;
    end
  end

  // Busy aggregation, one cycle of latency.
  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_any_busy <= 1'b0;
    end else begin
      r_any_busy <= |core_busy;
    end
  end

  assign w_push_entry.nonce = r_hold[w_winner];
  assign w_push_entry.core  = CORE_W_MAX'(w_winner);
  assign w_pop              = gn_valid && gn_ready;

  gn_fifo #(
    .WIDTH ($bits(gn_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (hash_clk),
    .rst_n   (reset_n),
    .i_push  (w_grant),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  // Head fields are forced to zero while empty so reset leaves clean outputs
  // even though the FIFO storage itself is not cleared.
  assign gn_valid   = !w_fifo_empty;
  assign gn_nonce   = gn_valid ? w_head.nonce : '0;
  assign gn_core    = gn_valid ? CORE_W'(w_head.core) : '0;
  assign any_busy   = r_any_busy;
  assign drop_cnt   = r_drop_cnt;
  assign fifo_level = w_fifo_count;

endmodule

// File: tb/tb_golden_nonce_arbiter.sv
// Bench for golden_nonce_arbiter: directed table, multi-cycle sequences and
// random traffic, all compared against a queue-based reference model.
module tb_golden_nonce_arbiter;

  localparam int NC    = 4;
  localparam int DEPTH = 8;

  logic          hash_clk = 1'b0;
  logic          reset_n;
  logic [NC-1:0] core_match;
  logic [32*NC-1:0] core_nonce;
  logic [NC-1:0] core_busy;
  logic          gn_valid;
  logic [31:0]   gn_nonce;
  logic [1:0]    gn_core;
  logic          gn_ready;
  logic          any_busy;
  logic [7:0]    drop_cnt;
  logic [3:0]    fifo_level;

  always #5 hash_clk = ~hash_clk;

  golden_nonce_arbiter #(
    .NUM_CORES  (NC),
    .FIFO_DEPTH (DEPTH),
    .CORE_W     (2)
  ) dut (
    .hash_clk   (hash_clk),
    .reset_n    (reset_n),
    .core_match (core_match),
    .core_nonce (core_nonce),
    .core_busy  (core_busy),
    .gn_valid   (gn_valid),
    .gn_nonce   (gn_nonce),
    .gn_core    (gn_core),
    .gn_ready   (gn_ready),
    .any_busy   (any_busy),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] nonce; int core; } ent_t;
  ent_t        mq[$];
  bit          m_pend [NC];
  logic [31:0] m_hold [NC];
  int          m_rr;
  int          m_drop;
  bit          m_busy;

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < NC; i++) begin
      m_pend[i] = 0;
      m_hold[i] = '0;
    end
    m_rr = 0; m_drop = 0; m_busy = 0;
  endtask

  task automatic model_edge(input logic [3:0] m, input logic [127:0] n,
                            input logic r, input logic [3:0] b);
    int w;
    int drops;
    bit pop;
    w = -1; drops = 0;
    pop = r && (mq.size() > 0);
    if (mq.size() < DEPTH) begin
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (m_rr + k) % NC;
        if (w < 0 && m_pend[c]) w = c;
      end
    end
    if (pop) mq.delete(0);
    if (w >= 0) begin
      mq.push_back('{m_hold[w], w});
      m_pend[w] = 0;
      m_rr = (w + 1) % NC;
    end
    for (int i = 0; i < NC; i++) begin
      if (m[i]) begin
        if (m_pend[i]) drops++;
        m_pend[i] = 1;
        m_hold[i] = n[32*i +: 32];
      end
    end
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    m_busy = |b;
  endtask

  task automatic check_model();
    chk("model_valid", gn_valid, mq.size() > 0);
    chk("model_level", fifo_level, mq.size());
    chk("model_drop", drop_cnt, m_drop);
    chk("model_busy", any_busy, m_busy);
    if (mq.size() > 0) begin
      chk("model_nonce", gn_nonce, mq[0].nonce);
      chk("model_core", gn_core, mq[0].core);
    end
  endtask

  // Drive at a falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input logic [3:0] m, input logic [127:0] n,
                      input logic r, input logic [3:0] b);
    core_match = m; core_nonce = n; gn_ready = r; core_busy = b;
    @(posedge hash_clk);
    model_edge(m, n, r, b);
    @(negedge hash_clk);
    check_model();
  endtask

  function automatic logic [127:0] nv(input int c, input logic [31:0] v);
    logic [127:0] t;
    t = '0;
    t[32*c +: 32] = v;
    return t;
  endfunction

  task automatic do_reset();
    core_match = '0; core_busy = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_valid", gn_valid, 0);
    chk("rst_async_level", fifo_level, 0);
    @(posedge hash_clk);
    @(negedge hash_clk);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", any_busy, 0);
    chk("rst_nonce", gn_nonce, 0);
    chk("rst_core", gn_core, 0);
    reset_n = 1'b1;
    model_clear();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]   m;
    logic [127:0] n;
    logic         r;
    logic         ev;
    logic [31:0]  en;
    logic [1:0]   ec;
    logic [3:0]   el;
    logic [7:0]   ed;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got[$];
    logic [31:0] gotn[$];
    int seen_old;

    // simultaneous matches from rr_ptr=0, then a single core-2 match
    tbl[0] = '{4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1, 1'b0, 32'h0,  2'd0, 4'd0, 8'd0};
    tbl[1] = '{4'h0, 128'h0, 1'b1, 1'b1, 32'hA0, 2'd0, 4'd1, 8'd0};
    tbl[2] = '{4'h0, 128'h0, 1'b1, 1'b1, 32'hA1, 2'd1, 4'd1, 8'd0};
    tbl[3] = '{4'h0, 128'h0, 1'b1, 1'b1, 32'hA2, 2'd2, 4'd1, 8'd0};
    tbl[4] = '{4'h0, 128'h0, 1'b1, 1'b1, 32'hA3, 2'd3, 4'd1, 8'd0};
    tbl[5] = '{4'h0, 128'h0, 1'b1, 1'b0, 32'h0,  2'd0, 4'd0, 8'd0};
    tbl[6] = '{4'h4, nv(2, 32'h7fbd9207), 1'b1, 1'b0, 32'h0, 2'd0, 4'd0, 8'd0};
    tbl[7] = '{4'h0, 128'h0, 1'b1, 1'b1, 32'h7fbd9207, 2'd2, 4'd1, 8'd0};
    tbl[8] = '{4'h0, 128'h0, 1'b1, 1'b0, 32'h0,  2'd0, 4'd0, 8'd0};

    reset_n = 1'b0; core_match = '0; core_nonce = '0; core_busy = 4'hF; gn_ready = 1'b0;
    model_clear();
    @(negedge hash_clk);
    @(negedge hash_clk);
    chk("init_valid", gn_valid, 0);
    chk("init_level", fifo_level, 0);
    chk("init_drop", drop_cnt, 0);
    chk("init_busy", any_busy, 0);
    chk("init_nonce", gn_nonce, 0);
    chk("init_core", gn_core, 0);
    reset_n = 1'b1; core_busy = '0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].m, tbl[i].n, tbl[i].r, 4'h0);
      chk($sformatf("tbl%0d_valid", i), gn_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].el);
      chk($sformatf("tbl%0d_drop", i), drop_cnt, tbl[i].ed);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_nonce", i), gn_nonce, tbl[i].en);
        chk($sformatf("tbl%0d_core", i), gn_core, tbl[i].ec);
      end
    end

    // fairness: bring rr_ptr to 2 via a core-1 grant, then cores 1+3 twice
    step(4'b0010, nv(1, 32'hF1), 1'b1, 4'h0);
    step(4'h0, '0, 1'b1, 4'h0);
    step(4'h0, '0, 1'b1, 4'h0);
    for (int rep = 0; rep < 2; rep++) begin
      got.delete();
      step(4'b1010, nv(1, 32'hB1) | nv(3, 32'hB3), 1'b1, 4'h0);
      for (int c = 0; c < 4; c++) begin
        step(4'h0, '0, 1'b1, 4'h0);
        if (gn_valid) got.push_back(int'(gn_core));
      end
      chk($sformatf("fair%0d_count", rep), got.size(), 2);
      chk($sformatf("fair%0d_first", rep), got[0], 3);
      chk($sformatf("fair%0d_second", rep), got[1], 1);
    end

    // backpressure: 10 single-core matches with ready low
    for (int j = 0; j < 10; j++) begin
      step(4'(1 << (j % 4)), nv(j % 4, 32'hC000_0000 + j), 1'b0, 4'h0);
    end
    for (int j = 0; j < 2; j++) begin
      step(4'h0, '0, 1'b0, 4'h0);
      chk("bp_level_full", fifo_level, 8);
      chk("bp_head_stable", gn_nonce, 32'hC000_0000);
    end
    gotn.delete();
    for (int j = 0; j < 14; j++) begin
      if (gn_valid) gotn.push_back(gn_nonce);
      step(4'h0, '0, 1'b1, 4'h0);
    end
    chk("bp_drain_count", gotn.size(), 10);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("bp_order%0d", j), gotn[j], 32'hC000_0000 + j);
    end

    // overwrite while full
    for (int j = 0; j < 8; j++) begin
      step(4'(1 << (1 + j % 3)), nv(1 + j % 3, 32'hE0 + j), 1'b0, 4'h0);
    end
    step(4'b0001, nv(0, 32'h11), 1'b0, 4'h0);
    step(4'b0001, nv(0, 32'h22), 1'b0, 4'h0);
    chk("ovw_drop", drop_cnt, 1);
    gotn.delete();
    for (int j = 0; j < 12; j++) begin
      if (gn_valid) gotn.push_back(gn_nonce);
      step(4'h0, '0, 1'b1, 4'h0);
    end
    seen_old = 0;
    foreach (gotn[j]) if (gotn[j] == 32'h11) seen_old++;
    chk("ovw_count", gotn.size(), 9);
    chk("ovw_last", gotn[gotn.size()-1], 32'h22);
    chk("ovw_no_old", seen_old, 0);

    // reset mid-stream with 5 queued
    for (int j = 0; j < 5; j++) begin
      step(4'(1 << (j % 4)), nv(j % 4, 32'h5000 + j), 1'b0, 4'h0);
    end
    step(4'h0, '0, 1'b0, 4'h0);
    chk("mid_level5", fifo_level, 5);
    do_reset();
    step(4'b0100, nv(2, 32'hD00D), 1'b1, 4'h0);
    chk("post_rst_lat1", gn_valid, 0);
    step(4'h0, '0, 1'b1, 4'h0);
    chk("post_rst_valid", gn_valid, 1);
    chk("post_rst_nonce", gn_nonce, 32'hD00D);
    chk("post_rst_core", gn_core, 2);
    step(4'h0, '0, 1'b1, 4'h0);

    // random traffic against the model
    for (int t = 0; t < 400; t++) begin
      logic [3:0]   m;
      logic [127:0] n;
      m = 4'($urandom() & $urandom());
      n = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(m, n, ($urandom_range(0, 3) != 0), 4'($urandom()));
    end

    // drop counter saturation: every core strobes every cycle into a full FIFO
    for (int t = 0; t < 80; t++) begin
      step(4'hF, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 4'h0);
    end
    chk("drop_saturated", drop_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/golden_nonce_arbiter.md
Name: golden_nonce_arbiter

Overview:
- Collects one-cycle golden-nonce match strobes from NUM_CORES hash cores, each core scanning its own nonce prefix.
- Serialises the matches through a round-robin grant into a show-ahead FIFO.
- Presents the FIFO head to the serial/JTAG comms layer over a valid/ready handshake, with the index of the reporting core.
- Also aggregates the cores' busy flags and counts dropped nonces.

Parameters:
- NUM_CORES, 4, number of hash cores served (2..16).
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2.
- CORE_W, 2, width of the core index; must equal clog2(NUM_CORES), minimum 1.

Ports:
- hash_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- core_match  in  NUM_CORES  per-core golden_nonce_match strobe, high for one cycle.
- core_nonce  in  32*NUM_CORES  per-core golden_nonce; core i occupies bits [32i+31:32i].
- core_busy  in  NUM_CORES  per-core miner_busy.
- gn_valid  out  1  FIFO non-empty.
- gn_nonce  out  32  FIFO head nonce.
- gn_core  out  CORE_W  FIFO head core index.
- gn_ready  in  1  consumer accepts the head.
- any_busy  out  1  registered OR of core_busy.
- drop_cnt  out  8  saturating count of lost nonces.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Clears pending[], holding nonces, rr_ptr, FIFO pointers and drop_cnt.
  - gn_valid=0, gn_nonce=0, gn_core=0, any_busy=0, fifo_level=0.
  - Reset asserted mid-operation discards all queued and pending nonces. No output glitch beyond the asynchronous clear.
- Capture stage, per core i on core_match[i]:
  - hold_nonce[i] <= core_nonce[i] and pending[i] <= 1.
  - If pending[i] was already set and core i is not granted this cycle, the old nonce is overwritten and drop_cnt increments.
  - Several cores matching in the same cycle all capture; no drop.
- Grant stage, combinational from registered pending[] and FIFO count:
  - Grant allowed only when count < FIFO_DEPTH. A pop in the same cycle does not free a slot for a grant.
  - Winner is the first pending core at or after rr_ptr, wrapping modulo NUM_CORES.
  - On grant: push {hold_nonce[w], w}, clear pending[w], set rr_ptr <= w+1 (mod NUM_CORES).
  - If core w matches again in its grant cycle, pending[w] stays 1 with the new nonce; not a drop.
- FIFO:
  - Show-ahead: gn_nonce/gn_core reflect the head whenever gn_valid=1.
  - Pop on gn_valid && gn_ready. Simultaneous push and pop keep the level unchanged.
  - Pointers wrap at FIFO_DEPTH.
  - gn_nonce/gn_core are don't-care when gn_valid=0; the bench must not check them then.
- Latency:
  - core_match sampled at edge k sets pending.
  - Grant and write occur at edge k+1.
  - gn_valid is high after edge k+1, i.e. 2 cycles from strobe to visible output with an empty FIFO and no contention.
- Full FIFO: pending entries wait and are never lost while waiting. Loss occurs only through a same-core overwrite.
- drop_cnt saturates at 255 and clears only on reset.
- any_busy <= |core_busy, 1-cycle latency.
- Handshake rules:
  - gn_valid never deasserts without a pop.
  - The head is stable while gn_valid=1 && gn_ready=0.

Decomposition:
- Shared package holds:
  - NONCE_W=32.
  - A clog2 function.
  - The gn_entry_t struct {nonce[31:0], core[CORE_W-1:0]}.
- One natural sub-module, gn_fifo: synchronous show-ahead FIFO, parameterised on width and depth, with count output.
- Round-robin grant and capture stay in the top level.

Test Plan:
- Single match: core 2 strobes nonce 32'h7fbd9207 at edge 10 -> gn_valid high after edge 11 with gn_nonce=32'h7fbd9207, gn_core=2. gn_ready=1 -> fifo_level returns to 0 after one cycle.
- Simultaneous matches: cores 0..3 strobe 32'hA0..A3 in one cycle with rr_ptr=0 and gn_ready=1 -> output order cores 0,1,2,3 on consecutive cycles, drop_cnt=0.
- Fairness: core 1 and core 3 strobe together twice, with rr_ptr=2 before the first -> order 3,1, then 3,1 again.
- Backpressure: gn_ready=0, 10 distinct single-core matches spread over the 4 cores -> fifo_level=8, two entries held pending, head stable. gn_ready=1 -> all 10 drain in grant order, none lost.
- Overwrite: core 0 matches 32'h11 then 32'h22 while the FIFO is full -> drop_cnt=1, output later shows 32'h22 only.
- Reset mid-stream: reset_n low with 5 queued -> gn_valid=0 and fifo_level=0 immediately (asynchronous). After release, a new match appears with 2-cycle latency.
